// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU data-side bridge: access sizes, bridge FSM states
// and the word byte-offset mask.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bridge_state_t;

  // Byte-offset bits within a 32-bit word.
  localparam logic [1:0] WORD_MASK = 2'b11;

  // The unused encoding 3 behaves as a full word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    mem_size_t sz;
    case (raw)
      2'd0:    sz = SZ_BYTE;
      2'd1:    sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// with sign/zero extension, and the misalignment flag.
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  mem_size_t   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size = decode_size(size_i);
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    byteen_o   = 4'b1111;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
        rdata_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        byteen_o   = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{signed_i & half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        misalign_o = |(addr_lo_i & WORD_MASK);
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_data_bridge.sv
// Data-side bridge: turns the core's single-cycle load/store into a waited,
// word-addressed bus access and stalls the core until the response cycle.
module mips_cpu_data_bridge
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  bridge_state_t     state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        addr_lo_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [3:0]        avm_be_q;
  logic [31:0]       avm_wd_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_error_q;

  logic [1:0]  lane_addr_d;
  logic [1:0]  lane_size_d;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] lane_rd;
  logic        lane_misalign;

  // In IDLE the lane logic looks at the live request; afterwards at the
  // registered one so load extraction uses the captured address and size.
  assign lane_addr_d = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign lane_size_d = (state_q == IDLE) ? req_size      : size_q;

  mips_cpu_lane_align u_lane_align (
    .addr_lo_i  (lane_addr_d),
    .size_i     (lane_size_d),
    .signed_i   (signed_q),
    .wdata_i    (req_wdata),
    .rdata_i    (avm_readdata),
    .byteen_o   (lane_be),
    .wdata_o    (lane_wd),
    .rdata_o    (lane_rd),
    .misalign_o (lane_misalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      addr_lo_q     <= 2'd0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      avm_write_q   <= 1'b0;
      avm_be_q      <= 4'd0;
      avm_wd_q      <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_error_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            if (lane_misalign) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else begin
              state_q       <= ACCESS;
              avm_address_q <= {req_addr[ADDR_W-1:2], 2'b00};
              avm_read_q    <= ~req_write;
              avm_write_q   <= req_write;
              avm_be_q      <= lane_be;
              avm_wd_q      <= req_write ? lane_wd : 32'd0;
            end
          end
        end
        ACCESS: begin
          // Outputs stay frozen until the slave drops waitrequest.
          if (!avm_waitrequest) begin
            state_q       <= RESP;
            avm_address_q <= '0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            avm_be_q      <= 4'd0;
            avm_wd_q      <= 32'd0;
            rsp_valid_q   <= 1'b1;
            rsp_error_q   <= 1'b0;
            rsp_rdata_q   <= write_q ? 32'd0 : lane_rd;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall          = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_byteenable = avm_be_q;
  assign avm_writedata  = avm_wd_q;

endmodule

// File: doc/mips_cpu_data_bridge.md
# mips_cpu_data_bridge

Data-side bridge directly downstream of the Harvard CPU core's data port. It converts the core's single-cycle load/store request into a multi-cycle, word-addressed bus transaction with byte enables and wait-state handling. It returns aligned, sign- or zero-extended load data, and stalls the core through its clock-enable path until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width on both sides.
- `RESET_VECTOR_UNUSED`, none: no parameters beyond `ADDR_W`.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: core presents a load or store this cycle.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2; the value 3 is illegal and treated as word.
- `req_signed`  in  1: sign-extend loads (LB/LH); 0 = zero-extend (LBU/LHU).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-justified.
- `stall`  out  1: core must hold its state; the core drives `clk_enable = ~stall`.
- `rsp_valid`  out  1: one-cycle pulse; load data or error is valid.
- `rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `rsp_error`  out  1: misaligned access; qualified by `rsp_valid`.
- `avm_address`  out  ADDR_W: word-aligned, with `[1:0]` forced to 0.
- `avm_read`, `avm_write`  out  1 each: bus strobes.
- `avm_byteenable`  out  4: lane enables, little-endian.
- `avm_writedata`  out  32: lane-replicated store data.
- `avm_readdata`  in  32: read data, valid in a cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`  in  1: slave not ready; the master holds all `avm_*` outputs stable.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`.
- `IDLE`:
  - If `req_valid` is 1, register addr/size/signed/write/wdata and compute misalignment.
  - Misalignment: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Misaligned: go to `RESP` with error set; no bus cycle is issued.
  - Aligned: go to `ACCESS`.
- `ACCESS`:
  - Drive `avm_read` or `avm_write` from the registered request.
  - While `avm_waitrequest`=1, stay in `ACCESS` with every output unchanged.
  - When `avm_waitrequest`=0, capture `avm_readdata` for a load, then go to `RESP`.
- `RESP`:
  - `rsp_valid`=1 for exactly one cycle, then unconditional return to `IDLE`.
  - `req_valid` is ignored in `RESP`; the core's next request is sampled in the following `IDLE` cycle.
- Byte enables: byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << addr[1:0]`; word → `4'b1111`.
- Write data: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
- Read extraction:
  - Byte: select lane `addr[1:0]`.
  - Half: select `[15:0]` or `[31:16]` by `addr[1]`.
  - Extend the selected field to 32 bits per `req_signed`.
  - Word: pass through unchanged.
- `stall` = (`IDLE` && `req_valid`) || `ACCESS`; it is combinational from `req_valid` in `IDLE`.

## Timing
- Reset values: state `IDLE`; every output 0, including the `avm_*` outputs, `stall`, `rsp_valid`, `rsp_rdata` and `rsp_error`. `stall` is 0 only while `req_valid`=0.
- Minimum latency, zero wait states:
  - Request seen at cycle 0.
  - Bus strobe at cycle 1.
  - `rsp_valid` at cycle 2, with `stall`=0 at cycle 2; the core advances on that edge.
- Each wait state adds exactly one cycle in `ACCESS`.
- Misaligned access: `rsp_valid`+`rsp_error` at cycle 1; `avm_read` and `avm_write` are never asserted.
- `rsp_rdata` is registered and stable throughout the `RESP` cycle.
- Reset asserted mid-`ACCESS`: state returns to `IDLE` and strobes drop immediately (asynchronously). The bus slave is expected to be reset by the same signal.
- `req_valid` deasserting during `ACCESS` has no effect; the registered request completes.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the `mem_size_t` enum (`SZ_BYTE`/`SZ_HALF`/`SZ_WORD`);
  - the `bridge_state_t` enum;
  - the localparam `WORD_MASK`.
- Sub-module `mips_cpu_lane_align` is purely combinational. It computes byte enables, write-data replication, read extraction/extension and the misalignment flag. The FSM, request registers and response registers stay in the top module.

## Test plan
- LW, `addr=0x1000`, `waitrequest`=0 → `avm_read` at cycle 1, `avm_address=0x1000`, `be=4'hF`; `readdata=0xDEADBEEF` gives `rsp_rdata=0xDEADBEEF` at cycle 2; `stall` is 1 for cycles 0–1 only.
- LB, `addr=0x1003`, `readdata=0x80AABBCC`, `signed`=1 → `be=4'b1000`, `rsp_rdata=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- SH, `addr=0x2002`, `wdata=0x1234ABCD`, 3 cycles of `waitrequest` → `avm_write` held 4 cycles, `be=4'b1100`, `writedata=0xABCDABCD`; `rsp_valid` at cycle 5.
- LW at `addr=0x1002` → no bus strobe; `rsp_error`=1 and `rsp_valid`=1 at cycle 1; `rsp_rdata=0`.
- Reset pulsed low during a waited `ACCESS` → `avm_read`, `stall` and `rsp_valid` drop to 0 in the same cycle, and the FSM is in `IDLE`. A subsequent LW completes normally.
